// File: rtl/fb_pkg.sv
// rtl/fb_pkg.sv - framebuffer arbiter shared types, widths and address packing helpers
package fb_pkg;

    localparam int FB_WORD_W = 16;
    localparam int FB_ADDR_W = 14;
    localparam int FB_XHI_W  = 6;
    localparam int FB_Y_W    = 8;
    localparam int FB_Y_LSB  = FB_XHI_W;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_A_RD,
        ST_A_PUSH,
        ST_B_RD,
        ST_B_MRG,
        ST_B_WR
    } fb_state_e;

    // Display word address layout: {2'b00, y[7:0], xhi[5:0]}
    function automatic logic [FB_WORD_W-1:0] fb_pack_addr(input logic [FB_Y_W-1:0]   y,
                                                          input logic [FB_XHI_W-1:0] xhi);
        return {2'b00, y, xhi};
    endfunction

endpackage

// File: rtl/fb_arb_prio.sv
// rtl/fb_arb_prio.sv - display/draw grant selection with draw starvation counter
module fb_arb_prio
    import fb_pkg::*;
#(
    parameter int BURST = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic eval_i,
    input  logic a_ready_i,
    input  logic b_ready_i,
    output logic grant_a_o,
    output logic grant_b_o
);

    localparam int             CNT_W   = $clog2(BURST + 1);
    localparam logic [CNT_W-1:0] BURST_C = CNT_W'(BURST);

    logic [CNT_W-1:0] cnt_q;

    // Draw only overtakes display once it has watched BURST display grants go by.
    always_comb begin
        grant_b_o = eval_i && b_ready_i && (!a_ready_i || (cnt_q == BURST_C));
        grant_a_o = eval_i && a_ready_i && !grant_b_o;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (!b_ready_i || grant_b_o) begin
            cnt_q <= '0;
        end else if (grant_a_o && (cnt_q != BURST_C)) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/fb_arbiter.sv
// rtl/fb_arbiter.sv - single-port framebuffer SRAM arbiter, display vs draw; FB_ARB_WMASK_EN enables masked RMW writes
module fb_arbiter
    import fb_pkg::*;
#(
    parameter int ADDR_W = FB_ADDR_W,
    parameter int BURST  = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 a_addr_empty,
    output logic                 a_addr_ren,
    input  logic [FB_WORD_W-1:0] a_addr_rd,
    input  logic                 a_data_full,
    output logic                 a_data_wen,
    output logic [FB_WORD_W-1:0] a_data_wd,
    input  logic                 b_req,
    input  logic                 b_we,
    input  logic [FB_WORD_W-1:0] b_addr,
    input  logic [FB_WORD_W-1:0] b_wd,
    input  logic [FB_WORD_W-1:0] b_wmask,
    output logic                 b_ack,
    output logic [FB_WORD_W-1:0] b_rd,
    output logic                 mem_en,
    output logic                 mem_we,
    output logic [ADDR_W-1:0]    mem_addr,
    output logic [FB_WORD_W-1:0] mem_wd,
    input  logic [FB_WORD_W-1:0] mem_rd
);

`ifdef FB_ARB_WMASK_EN
    localparam bit WMASK_EN = 1'b1;
`else
    localparam bit WMASK_EN = 1'b0;
`endif

    fb_state_e            state_q;
    logic                 bad_q;
    logic                 a_ok, b_ok, a_ready, b_ready, grant_a, grant_b;
    logic [FB_WORD_W-1:0] mrg_d;

    always_comb begin
        a_ok    = (a_addr_rd >> ADDR_W) == '0;
        b_ok    = (b_addr >> ADDR_W) == '0;
        a_ready = !a_addr_empty && !a_data_full;
        // The ack cycle still sees the completed request's b_req; don't re-serve it.
        b_ready = b_req && !b_ack;
        mrg_d   = (mem_rd & ~b_wmask) | (b_wd & b_wmask);
    end

    fb_arb_prio #(.BURST(BURST)) u_prio (
        .clk       (clk),
        .rst       (rst),
        .eval_i    (state_q == ST_IDLE),
        .a_ready_i (a_ready),
        .b_ready_i (b_ready),
        .grant_a_o (grant_a),
        .grant_b_o (grant_b)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            bad_q      <= 1'b0;
            a_addr_ren <= 1'b0;
            a_data_wen <= 1'b0;
            a_data_wd  <= '0;
            b_ack      <= 1'b0;
            b_rd       <= '0;
            mem_en     <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wd     <= '0;
        end else begin
            a_addr_ren <= 1'b0;
            a_data_wen <= 1'b0;
            b_ack      <= 1'b0;
            mem_en     <= 1'b0;
            mem_we     <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (grant_a) begin
                        bad_q      <= !a_ok;
                        a_addr_ren <= 1'b1;
                        mem_en     <= a_ok;
                        mem_addr   <= a_addr_rd[ADDR_W-1:0];
                        state_q    <= ST_A_RD;
                    end else if (grant_b) begin
                        bad_q    <= !b_ok;
                        mem_en   <= b_ok;
                        mem_addr <= b_addr[ADDR_W-1:0];
                        if (b_we && !WMASK_EN) begin
                            mem_we  <= b_ok;
                            mem_wd  <= b_wd;
                            state_q <= ST_B_WR;
                        end else begin
                            state_q <= ST_B_RD;
                        end
                    end
                end
                ST_A_RD:   state_q <= ST_A_PUSH;
                ST_A_PUSH: begin
                    a_data_wd  <= bad_q ? '0 : mem_rd;
                    a_data_wen <= 1'b1;
                    state_q    <= ST_IDLE;
                end
                ST_B_RD:   state_q <= ST_B_MRG;
                ST_B_MRG: begin
                    if (b_we && WMASK_EN) begin
                        mem_en  <= !bad_q;
                        mem_we  <= !bad_q;
                        mem_wd  <= mrg_d;
                        state_q <= ST_B_WR;
                    end else begin
                        b_rd    <= bad_q ? '0 : mem_rd;
                        b_ack   <= 1'b1;
                        state_q <= ST_IDLE;
                    end
                end
                ST_B_WR: begin
                    b_ack   <= 1'b1;
                    state_q <= ST_IDLE;
                end
                default:   state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fb_arbiter.sv
// tb/tb_fb_arbiter.sv - directed scoreboard bench for fb_arbiter
module tb_fb_arbiter;
    import fb_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        a_addr_empty = 1'b1;
    logic        a_addr_ren;
    logic [15:0] a_addr_rd = 16'h0;
    logic        a_data_full = 1'b0;
    logic        a_data_wen;
    logic [15:0] a_data_wd;
    logic        b_req = 1'b0;
    logic        b_we = 1'b0;
    logic [15:0] b_addr = 16'h0;
    logic [15:0] b_wd = 16'h0;
    logic [15:0] b_wmask = 16'h0;
    logic        b_ack;
    logic [15:0] b_rd;
    logic        mem_en;
    logic        mem_we;
    logic [13:0] mem_addr;
    logic [15:0] mem_wd;
    logic [15:0] mem_rd = 16'h0;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int ren_count = 0;
    int ack_count = 0;
    int men_count = 0;
    int wr_count = 0;

    logic [15:0] sram [0:16383];
    logic [15:0] fifo_q [$];
    logic [15:0] exp_q [$];
    int          ren_cyc_q [$];

    fb_arbiter #(.ADDR_W(14), .BURST(4)) dut (
        .clk(clk), .rst(rst),
        .a_addr_empty(a_addr_empty), .a_addr_ren(a_addr_ren), .a_addr_rd(a_addr_rd),
        .a_data_full(a_data_full), .a_data_wen(a_data_wen), .a_data_wd(a_data_wd),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wd(b_wd), .b_wmask(b_wmask),
        .b_ack(b_ack), .b_rd(b_rd),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wd(mem_wd), .mem_rd(mem_rd)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic fifo_refresh();
        a_addr_empty = (fifo_q.size() == 0);
        a_addr_rd    = (fifo_q.size() == 0) ? 16'h0 : fifo_q[0];
    endtask

    task automatic push_disp(input logic [15:0] addr, input logic [15:0] exp);
        fifo_q.push_back(addr);
        exp_q.push_back(exp);
        fifo_refresh();
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 300; i++) begin
            if (exp_q.size() == 0 && fifo_q.size() == 0) break;
            @(negedge clk);
        end
        chk("drain_timeout", exp_q.size(), 0);
    endtask

    task automatic draw(input logic we, input logic [15:0] addr, input logic [15:0] wd,
                        input logic [15:0] mask, output logic [15:0] rd, output int rens);
        int  r0;
        bit  got;
        r0 = ren_count;
        got = 1'b0;
        rd = 16'hxxxx;
        b_req = 1'b1; b_we = we; b_addr = addr; b_wd = wd; b_wmask = mask;
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge clk);
            if (b_ack) begin
                got = 1'b1;
                rd = b_rd;
            end
        end
        b_req = 1'b0;
        rens = ren_count - r0;
        chk("draw_ack_seen", got, 1);
    endtask

    // Environment: FWFT address FIFO and 1-cycle-latency SRAM
    always @(posedge clk) begin
        if (a_addr_ren && fifo_q.size() != 0) begin
            void'(fifo_q.pop_front());
            fifo_refresh();
        end
        if (mem_en) begin
            if (mem_we) begin
                sram[mem_addr] = mem_wd;
                wr_count++;
            end else begin
                mem_rd <= sram[mem_addr];
            end
        end
    end

    always @(negedge clk) begin
        cyc++;
        if (a_addr_ren) begin
            ren_count++;
            ren_cyc_q.push_back(cyc);
        end
        if (b_ack) ack_count++;
        if (mem_en) men_count++;
        if (a_data_wen) begin
            if (exp_q.size() == 0 || ren_cyc_q.size() == 0) begin
                chk("disp_unexpected_push", 1, 0);
            end else begin
                chk("disp_data", a_data_wd, exp_q.pop_front());
                chk("disp_latency", cyc - ren_cyc_q.pop_front(), 2);
            end
        end
    end

    initial begin
        logic [15:0] rd;
        int          rens, m0, a0, r0, w0;

        for (int i = 0; i < 16384; i++) sram[i] = 16'(i * 3);
        sram[14'h0123] = 16'hA5A5;
        sram[14'h0010] = 16'h1234;
        sram[14'h0020] = 16'hFFFF;
        sram[14'h0030] = 16'h5555;
        sram[14'h0000] = 16'h7777;

        repeat (3) @(negedge clk);
        chk("rst_a_addr_ren", a_addr_ren, 0);
        chk("rst_a_data_wen", a_data_wen, 0);
        chk("rst_b_ack", b_ack, 0);
        chk("rst_mem_en", mem_en, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_data_words", {a_data_wd, b_rd}, 32'h0);
        chk("rst_mem_addr_wd", {2'b00, mem_addr, mem_wd}, 32'h0);
        rst = 1'b0;
        @(negedge clk);

        // Single display fetch
        push_disp(fb_pack_addr(8'h04, 6'h23), 16'hA5A5);
        wait_drain();
        chk("single_disp_grants", ren_count, 1);

        // Data FIFO full blocks display grants
        a_data_full = 1'b1;
        m0 = men_count; r0 = ren_count;
        push_disp(16'h0050, 16'(16'h0050 * 3));
        repeat (10) @(negedge clk);
        chk("full_no_ren", ren_count - r0, 0);
        chk("full_no_mem_en", men_count - m0, 0);
        a_data_full = 1'b0;
        wait_drain();

        // Draw read waits exactly BURST display grants under continuous traffic
        for (int i = 0; i < 10; i++) push_disp(16'(16'h0100 + i), 16'((16'h0100 + i) * 3));
        draw(1'b0, 16'h0010, 16'h0, 16'h0, rd, rens);
        chk("burst_read_data", rd, 16'h1234);
        chk("burst_display_grants", rens, 4);
        wait_drain();

        // Masked write
        draw(1'b1, 16'h0020, 16'h0000, 16'h00F0, rd, rens);
`ifdef FB_ARB_WMASK_EN
        chk("wmask_sram", sram[14'h0020], 16'hFF0F);
        draw(1'b0, 16'h0020, 16'h0, 16'h0, rd, rens);
        chk("wmask_readback", rd, 16'hFF0F);
`else
        chk("wmask_sram", sram[14'h0020], 16'h0000);
        draw(1'b0, 16'h0020, 16'h0, 16'h0, rd, rens);
        chk("wmask_readback", rd, 16'h0000);
`endif

        // Out-of-range addresses never touch SRAM
        m0 = men_count;
        push_disp(16'h4000, 16'h0000);
        wait_drain();
        chk("oor_disp_no_mem_en", men_count - m0, 0);
        m0 = men_count; w0 = wr_count;
        draw(1'b1, 16'hC000, 16'hBEEF, 16'hFFFF, rd, rens);
        chk("oor_write_no_mem_en", men_count - m0, 0);
        chk("oor_write_sram", sram[14'h0000], 16'h7777);
        chk("oor_write_count", wr_count - w0, 0);
        draw(1'b0, 16'h8010, 16'h0, 16'h0, rd, rens);
        chk("oor_read_zero", rd, 16'h0000);

        // Reset during the write cycle
        b_req = 1'b1; b_we = 1'b1; b_addr = 16'h0030; b_wd = 16'hAAAA; b_wmask = 16'hFFFF;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (mem_we) break;
        end
        chk("rst_mid_we_seen", mem_we, 1);
        a0 = ack_count; w0 = wr_count;
        rst = 1'b1;
        #1;
        chk("rst_mid_mem_we", mem_we, 0);
        chk("rst_mid_b_ack", b_ack, 0);
        b_req = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        chk("rst_mid_no_ack", ack_count - a0, 0);
        chk("rst_mid_no_write", wr_count - w0, 0);
        chk("rst_mid_sram", sram[14'h0030], 16'h5555);
        push_disp(16'h0123, 16'hA5A5);
        wait_drain();
        draw(1'b0, 16'h0030, 16'h0, 16'h0, rd, rens);
        chk("rst_recover_read", rd, 16'h5555);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fb_arbiter.md
FB_ARBITER -- requirements
Module: fb_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 14, framebuffer word-address width (16K x 16-bit words, 2 bpp).
REQ-002 SHALL have parameter BURST, default 4, maximum consecutive display grants while the draw port waits.
REQ-003 SHALL have ports: clk  in  1  sole clock, rising edge; rst  in  1  reset, asynchronous, active-high.
REQ-004 SHALL have display address-FIFO read-side ports (first-word-fall-through): a_addr_empty  in  1; a_addr_ren  out  1  pop; a_addr_rd  in  16  word address {2'b00,y[7:0],xhi[5:0]}.
REQ-005 SHALL have display data-FIFO write-side ports: a_data_full  in  1; a_data_wen  out  1  push; a_data_wd  out  16  read word.
REQ-006 SHALL have draw-engine ports: b_req  in  1; b_we  in  1  write when 1; b_addr  in  16; b_wd  in  16; b_wmask  in  16  bit-enable; b_ack  out  1  one-cycle completion pulse; b_rd  out  16  read data, valid with b_ack.
REQ-007 SHALL have single-port synchronous SRAM ports with 1-cycle read latency: mem_en  out  1; mem_we  out  1; mem_addr  out  ADDR_W; mem_wd  out  16; mem_rd  in  16.

Function
REQ-008 SHALL implement FSM states IDLE, A_RD, A_PUSH, B_RD, B_MRG, B_WR; every output registered.
REQ-009 In IDLE, display is ready iff ~a_addr_empty && ~a_data_full; draw is ready iff b_req.
REQ-010 SHALL grant display when ready, unless draw is ready and starvation counter equals BURST, in which case draw is granted.
REQ-011 Starvation counter SHALL increment on each display grant while b_req is high, clear on each draw grant or when b_req is low, and saturate at BURST.
REQ-012 Display grant (A_RD): a_addr_ren=1 for one cycle, mem_en=1, mem_we=0, mem_addr=a_addr_rd[ADDR_W-1:0]; next cycle A_PUSH latches mem_rd; a_data_wen=1 with a_data_wd one cycle after that; FSM returns to IDLE.
REQ-013 Display latency SHALL be exactly 2 cycles from a_addr_ren pulse to a_data_wen pulse; at most one display word in flight.
REQ-014 Draw read: B_RD issues read, B_MRG captures mem_rd; b_ack=1 with b_rd valid the following cycle; return to IDLE.
REQ-015 Draw write: behaviour per Configuration; b_ack pulses exactly once per accepted request; b_req SHALL be held by the requester until b_ack and may be re-asserted the cycle after.
REQ-016 Address bits [15:ADDR_W] nonzero: no SRAM access (mem_en=0); display pushes 16'h0000; draw read returns 16'h0000; draw write is dropped; handshake timing unchanged.
REQ-017 a_data_full rising during A_RD/A_PUSH SHALL NOT block the in-flight push (FIFO guarantees one slot margin by REQ-009 check).
REQ-018 Simultaneous readiness with counter < BURST: display wins; with counter == BURST: draw wins.

Reset
REQ-019 On rst: FSM IDLE, counter 0, a_addr_ren, a_data_wen, b_ack, mem_en, mem_we 0, a_data_wd, b_rd, mem_addr, mem_wd 0.
REQ-020 Reset mid-transaction SHALL abandon the access without an ack or push; no SRAM write may occur in the reset cycle.

Configuration
REQ-021 Macro FB_ARB_WMASK_EN defined: draw write is read-modify-write B_RD -> B_MRG -> B_WR, mem_wd = (old & ~b_wmask) | (b_wd & b_wmask); b_ack in cycle after B_WR.
REQ-022 FB_ARB_WMASK_EN undefined: draw write goes IDLE -> B_WR directly, full-word write of b_wd, b_wmask ignored, b_ack next cycle.

Structure
REQ-023 Package fb_pkg SHALL hold FB_WORD_W=16, FB_ADDR_W=14, the FSM state enum and the address-packing helper constants.
REQ-024 Grant selection plus starvation counter SHALL be one sub-module, fb_arb_prio; FSM and datapath stay in fb_arbiter.

Verification
REQ-025 Display only: push addr 16'h0123, SRAM[0x123]=16'hA5A5 -> a_addr_ren, then 2 cycles later a_data_wen with 16'hA5A5.
REQ-026 Continuous display traffic plus held b_req read of 0x0010 -> b_ack after exactly 4 display grants (BURST=4).
REQ-027 WMASK_EN: SRAM[0x0020]=16'hFFFF, write b_wd=16'h0000 b_wmask=16'h00F0 -> SRAM[0x0020]=16'hFF0F; without macro -> 16'h0000.
REQ-028 a_data_full=1 with nonempty addr FIFO and no b_req -> no a_addr_ren, mem_en stays 0.
REQ-029 Display addr 16'h4000 -> no mem_en, a_data_wd=16'h0000 pushed; draw write 16'hC000 -> b_ack, SRAM unchanged.
REQ-030 rst asserted in B_WR -> mem_we 0 that cycle, no b_ack, FSM IDLE after release.
